// File: rtl/fifo_drain_packer_pkg.sv
// rtl/fifo_drain_packer_pkg.sv - shared defaults and state encoding for the drain packer
package fifo_drain_packer_pkg;

    localparam int DEPTH_DEF  = 16;  // rows drained per start
    localparam int LANES_DEF  = 16;  // lanes per row
    localparam int IN_W_DEF   = 20;  // signed input lane width
    localparam int OUT_W_DEF  = 8;   // signed output lane width
    localparam int SHIFT_W    = 5;   // width of the right-shift amount
    localparam int ROWCNT_W   = 5;   // row counter width, DEPTH must fit

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_round_q20to8.sv
// rtl/sat_round_q20to8.sv - one lane of round-half-up right shift with signed saturation
//
// Ports:
//   din_i   signed IN_W-bit lane value
//   shift_i right-shift amount; values >= IN_W collapse the lane to 0 / -1
//   dout_o  signed OUT_W-bit rounded, shifted, saturated value
module sat_round_q20to8
    import fifo_drain_packer_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]    din_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [OUT_W-1:0]   dout_o
);

    localparam logic signed [IN_W:0] ONE     = (IN_W+1)'(1);
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-(1 << (OUT_W-1)));

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shr;

    // One guard bit keeps ext + rnd from overflowing for every shift < IN_W.
    always_comb begin
        ext = {din_i[IN_W-1], din_i};
        rnd = '0;
        if (shift_i != '0) begin
            rnd = ONE << (shift_i - SHIFT_W'(1));
        end
        sum = ext + rnd;
        shr = sum >>> shift_i;
        // Large shifts leave only the sign; the rounding term is meaningless there.
        if ({27'd0, shift_i} >= IN_W) begin
            shr = din_i[IN_W-1] ? '1 : '0;
        end
        if (shr > SAT_MAX) begin
            dout_o = SAT_MAX[OUT_W-1:0];
        end else if (shr < SAT_MIN) begin
            dout_o = SAT_MIN[OUT_W-1:0];
        end else begin
            dout_o = shr[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fifo_drain_packer.sv
// rtl/fifo_drain_packer.sv - drains DEPTH rows from a shift FIFO into quantized output beats
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   start, shift  drain request pulse and right-shift amount captured with it
//   fifo_dout     oldest upstream row, lane k at [IN_W*k +: IN_W]
//   fifo_en       pops one upstream row this cycle
//   m_data        quantized row, lane k at [OUT_W*k +: OUT_W]
//   m_valid/ready output beat handshake
//   busy, done    not idle / one-cycle completion pulse
module fifo_drain_packer
    import fifo_drain_packer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LANES = LANES_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [SHIFT_W-1:0]     shift,
    input  logic [LANES*IN_W-1:0]  fifo_dout,
    output logic                   fifo_en,
    output logic [LANES*OUT_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ROWCNT_W-1:0] DEPTH_C = ROWCNT_W'(DEPTH);

    state_e                   state_q, state_d;
    logic [ROWCNT_W-1:0]      rowcnt_q, rowcnt_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic [LANES*OUT_W-1:0]   data_q, data_d;
    logic                     valid_q, valid_d;
    logic [LANES*OUT_W-1:0]   quant_row;
    logic                     out_free;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sat_round_q20to8 #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_sat (
            .din_i   (fifo_dout[IN_W*k +: IN_W]),
            .shift_i (shift_q),
            .dout_o  (quant_row[OUT_W*k +: OUT_W])
        );
    end

    // The output register can take a new row when empty or being consumed now.
    assign out_free = !valid_q || m_ready;
    assign fifo_en  = (state_q == ST_DRAIN) && (rowcnt_q < DEPTH_C) && out_free;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign m_data   = data_q;
    assign m_valid  = valid_q;

    always_comb begin
        state_d  = state_q;
        rowcnt_d = rowcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;

        if (fifo_en) begin
            data_d   = quant_row;
            valid_d  = 1'b1;
            rowcnt_d = rowcnt_q + ROWCNT_W'(1);
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRAIN;
                    shift_d  = shift;
                    rowcnt_d = '0;
                end
            end
            ST_DRAIN: begin
                // Last beat leaves on the same edge that moves to DONE.
                if ((rowcnt_q == DEPTH_C) && out_free) begin
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rowcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rowcnt_q <= rowcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// tb/tb_fifo_drain_packer.sv - directed self-checking bench for fifo_drain_packer
module tb_fifo_drain_packer;

    localparam int DEPTH = 16;
    localparam int LANES = 16;
    localparam int IN_W  = 20;
    localparam int OUT_W = 8;
    localparam int DW    = LANES*OUT_W;

    logic                  clk;
    logic                  reset_n;
    logic                  start;
    logic [4:0]            shift;
    logic [LANES*IN_W-1:0] fifo_dout;
    logic                  fifo_en;
    logic [DW-1:0]         m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  busy;
    logic                  done;

    fifo_drain_packer #(
        .DEPTH (DEPTH),
        .LANES (LANES),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .shift     (shift),
        .fifo_dout (fifo_dout),
        .fifo_en   (fifo_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [IN_W-1:0] lane_tab [LANES];
    bit              add_row;
    int              rd_ptr;
    logic [DW-1:0]   got [$];
    int              cyc, en_cnt, done_cnt, first_cyc, last_cyc, done_cyc;
    bit              busy_probe;
    logic            busy_after;

    int         q_sh   [14];
    int         q_lane [14];
    logic [7:0] q_exp  [14];

    task automatic chk(input string tag, input logic [DW-1:0] got_v, input logic [DW-1:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] rep(input int v);
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*OUT_W +: OUT_W] = OUT_W'(v);
        return r;
    endfunction

    function automatic logic [LANES*IN_W-1:0] row_word(input int p);
        logic [LANES*IN_W-1:0] w;
        for (int k = 0; k < LANES; k++)
            w[k*IN_W +: IN_W] = lane_tab[k] + (add_row ? IN_W'(p) : IN_W'(0));
        return w;
    endfunction

    task automatic drive_row();
        fifo_dout = row_word(rd_ptr);
    endtask

    task automatic clear_stats();
        got.delete();
        en_cnt = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        busy_probe = 0; busy_after = 1'bx;
    endtask

    task automatic observe();
        if (m_valid && m_ready) begin
            got.push_back(m_data);
            if (got.size() == 1) first_cyc = cyc;
            last_cyc = cyc;
        end
        if (busy_probe) begin
            busy_after = busy;
            busy_probe = 0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_probe = 1;
        end
    endtask

    // One clock: observe at the falling edge, sample fifo_en just before the
    // rising edge, then pop the FIFO model after the edge if it was enabled.
    task automatic tick();
        bit en_s;
        @(negedge clk);
        cyc++;
        observe();
        #4;
        en_s = fifo_en;
        if (en_s) en_cnt++;
        @(posedge clk);
        #1;
        if (en_s) begin
            rd_ptr++;
            drive_row();
        end
    endtask

    task automatic start_drain(input int sh);
        start = 1'b1;
        shift = 5'(sh);
        tick();
        start = 1'b0;
    endtask

    task automatic finish_drain(input int max_cyc);
        int  d0;
        bit  ok;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            tick();
            if (done_cnt != d0) ok = 1;
        end
        chk("drain_completes", ok, 1);
        tick();
    endtask

    task automatic ramp_rows();
        for (int k = 0; k < LANES; k++) lane_tab[k] = '0;
        add_row = 1;
        rd_ptr  = 0;
        drive_row();
    endtask

    initial begin
        int c0;
        logic [DW-1:0] b;

        cyc = 0;
        reset_n = 1'b0; start = 1'b0; shift = '0; m_ready = 1'b1;
        ramp_rows();
        clear_stats();

        #2;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_fifo_en", fifo_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Full drain, ramp rows, unthrottled sink.
        ramp_rows(); clear_stats();
        start_drain(0);
        c0 = cyc + 1;
        chk("c0_m_valid", m_valid, 0);
        #2;
        chk("c0_busy", busy, 1);
        chk("c0_fifo_en", fifo_en, 1);
        finish_drain(40);
        chk("full_beats", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk($sformatf("full_beat%0d", i), got[i], rep(i));
        chk("full_en_cnt", en_cnt, 16);
        chk("full_first_lat", first_cyc - c0, 1);
        chk("full_back_to_back", last_cyc - first_cyc, 15);
        chk("full_done_after_last", done_cyc - last_cyc, 1);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_busy_after", busy_after, 0);

        // Quantization vectors, constant rows.
        lane_tab[0] = 20'h7FFFF; lane_tab[1] = 20'h80000; lane_tab[2] = 20'd40;
        lane_tab[3] = 20'hFFFFB; lane_tab[4] = 20'd0;     lane_tab[5] = 20'hFFFFD;
        for (int k = 6; k < LANES; k++) lane_tab[k] = '0;
        add_row = 0; rd_ptr = 0; drive_row();
        q_sh   = '{4, 4, 3, 1, 20, 20, 31, 31, 0, 0, 0, 19, 19, 1};
        q_lane = '{0, 1, 2, 3, 0, 1, 3, 2, 2, 0, 1, 0, 1, 5};
        q_exp  = '{8'h7F, 8'h80, 8'h05, 8'hFE, 8'h00, 8'hFF, 8'hFF, 8'h00,
                   8'h28, 8'h7F, 8'h80, 8'h01, 8'hFF, 8'hFF};
        for (int t = 0; t < 14; t++) begin
            clear_stats();
            start_drain(q_sh[t]);
            finish_drain(40);
            b = (got.size() > 0) ? got[0] : '0;
            chk($sformatf("quant_sh%0d_lane%0d", q_sh[t], q_lane[t]),
                DW'(b[q_lane[t]*OUT_W +: OUT_W]), DW'(q_exp[t]));
        end

        // Backpressure after beat 3.
        ramp_rows(); clear_stats();
        start_drain(0);
        for (int i = 0; i < 20 && got.size() < 4; i++) tick();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk($sformatf("bp_valid%0d", i), m_valid, 1);
            chk($sformatf("bp_fifo_en%0d", i), fifo_en, 0);
            chk($sformatf("bp_data%0d", i), m_data, rep(4));
            tick();
        end
        m_ready = 1'b1;
        finish_drain(40);
        chk("bp_beats", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk($sformatf("bp_beat%0d", i), got[i], rep(i));
        chk("bp_en_cnt", en_cnt, 16);
        chk("bp_done_cnt", done_cnt, 1);

        // start re-pulsed mid-drain is ignored.
        ramp_rows(); clear_stats();
        start_drain(0);
        tick(); tick(); tick();
        start = 1'b1; tick(); tick(); start = 1'b0;
        finish_drain(40);
        for (int i = 0; i < 4; i++) tick();
        chk("restart_beats", got.size(), 16);
        chk("restart_last_beat", (got.size() == 16) ? got[15] : '0, rep(15));
        chk("restart_done_cnt", done_cnt, 1);
        chk("restart_en_cnt", en_cnt, 16);
        chk("restart_idle", busy, 0);

        // Asynchronous reset after beat 7, then a fresh drain.
        ramp_rows(); clear_stats();
        start_drain(0);
        for (int i = 0; i < 30 && got.size() < 7; i++) tick();
        @(negedge clk);
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_beat7", m_data, rep(7));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_m_valid", m_valid, 0);
        chk("async_m_data", m_data, 0);
        chk("async_fifo_en", fifo_en, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("rst_rows_popped", rd_ptr, 8);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle", busy, 0);
        clear_stats();
        start_drain(0);
        finish_drain(40);
        chk("fresh_beats", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk($sformatf("fresh_beat%0d", i), got[i], rep(8 + i));
        chk("fresh_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_drain_packer.md
FIFO_DRAIN_PACKER -- requirements
Module: fifo_drain_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning rows drained per start.
REQ-002 SHALL have parameter LANES, default 16, meaning lanes per row.
REQ-003 SHALL have parameter IN_W, default 20, meaning signed input lane width.
REQ-004 SHALL have parameter OUT_W, default 8, meaning signed output lane width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, pulse that requests a drain of DEPTH rows.
REQ-008 SHALL have port shift, input, 5, right-shift amount, sampled on accepted start.
REQ-009 SHALL have port fifo_dout, input, LANES*IN_W, oldest row of the upstream shift FIFO; lane k is bits [IN_W*k+IN_W-1 : IN_W*k].
REQ-010 SHALL have port fifo_en, output, 1, advances the upstream FIFO by one row.
REQ-011 SHALL have port m_data, output, LANES*OUT_W, packed quantized row; lane k is bits [OUT_W*k+OUT_W-1 : OUT_W*k].
REQ-012 SHALL have port m_valid, output, 1, m_data holds an unconsumed beat.
REQ-013 SHALL have port m_ready, input, 1, downstream accepts a beat when m_valid && m_ready.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when a drain completes.

Function
REQ-016 SHALL implement states IDLE, DRAIN, DONE.
REQ-017 IDLE: start=1 at an edge -> latch shift, clear row counter, go DRAIN; start ignored in DRAIN and DONE.
REQ-018 fifo_en SHALL be combinational: (state==DRAIN) && (rowcnt<DEPTH) && (!m_valid || m_ready).
REQ-019 On every edge where fifo_en=1: m_data <= quant(fifo_dout), m_valid <= 1, rowcnt <= rowcnt+1 (rowcnt is 5 bits, no wrap).
REQ-020 An edge with m_valid && m_ready and no fifo_en SHALL clear m_valid.
REQ-021 m_data SHALL be stable while m_valid && !m_ready.
REQ-022 DRAIN with rowcnt==DEPTH and (!m_valid || m_ready) -> DONE; m_valid cleared on that edge.
REQ-023 DONE: done=1 for exactly that cycle, then IDLE unconditionally.
REQ-024 Throughput with m_ready held high: one beat per cycle; first m_valid one cycle after the first DRAIN cycle.
REQ-025 quant per lane: sign-extend to IN_W+1 bits, add 1<<(shift-1) if shift>0, arithmetic right shift by shift, saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 shift values >= IN_W SHALL yield 0 for non-negative lanes and -1 for negative lanes (pre-saturation).
REQ-027 busy SHALL equal (state != IDLE), combinationally from the state register.

Reset
REQ-028 reset_n low SHALL asynchronously force state=IDLE, rowcnt=0, latched shift=0, m_data=0, m_valid=0, done=0; fifo_en and busy are then 0.
REQ-029 Reset mid-drain SHALL abandon the drain with no done pulse; rows already advanced are not replayed.

Structure
REQ-030 DEPTH, LANES, IN_W, OUT_W defaults and the state encodings SHALL live in the shared TPU definitions header.
REQ-031 Per-lane rounding/saturation SHALL be one combinational sub-module, sat_round_q20to8, instantiated LANES times.

Verification
REQ-032 Reset: assert reset_n=0 mid-cycle -> all outputs 0 immediately, independent of clk.
REQ-033 Full drain: shift=0, m_ready=1, row r has all lanes = r, start pulse -> 16 consecutive beats with lanes 0x00..0x0F, 16 fifo_en cycles, done one cycle after the last beat, busy low next cycle.
REQ-034 Quantization: shift=4, lanes 0x7FFFF / 0x80000 / 40 (shift=3) / -5 (shift=1) -> 0x7F / 0x80 / 0x05 / 0xFE.
REQ-035 Backpressure: m_ready=0 for 5 cycles after beat 3 -> m_data stable, fifo_en=0, m_valid=1 throughout; all 16 beats delivered in order.
REQ-036 start re-pulsed during DRAIN -> ignored, exactly 16 beats and one done.
REQ-037 reset_n pulsed after beat 7 -> state IDLE, no done; a new start then drains 16 fresh rows.
